// File: rtl/pipe_buf.sv
// Elastic pipeline stage buffer: a DEPTH-entry FIFO with a valid/ready handshake,
// synchronous flush for squash, and a BUBBLE payload presented while empty.
module pipe_buf #(
    parameter int unsigned          DATA_W = 64,
    parameter int unsigned          DEPTH  = 2,
    parameter logic [DATA_W-1:0]    BUBBLE = '0
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         flush_i,
    input  logic                         in_valid_i,
    output logic                         in_ready_o,
    input  logic [DATA_W-1:0]            in_data_i,
    output logic                         out_valid_o,
    input  logic                         out_ready_i,
    output logic [DATA_W-1:0]            out_data_o,
    output logic [$clog2(DEPTH+1)-1:0]   count_o
);

    localparam int unsigned CntW = $clog2(DEPTH + 1);
    localparam int unsigned PtrW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [PtrW-1:0] LastPtr = PtrW'(DEPTH - 1);
    localparam logic [CntW-1:0] FullCnt = CntW'(DEPTH);

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [PtrW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PtrW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CntW-1:0]   count_q, count_d;
    logic              push, pop;

    // Explicit wrap so non-power-of-two depths step 0..DEPTH-1.
    function automatic logic [PtrW-1:0] ptr_next(input logic [PtrW-1:0] ptr);
        return (ptr == LastPtr) ? '0 : ptr + PtrW'(1);
    endfunction

    // Handshake outputs depend only on registered state.
    always_comb begin
        in_ready_o  = (count_q != FullCnt);
        out_valid_o = (count_q != '0);
        out_data_o  = out_valid_o ? mem_q[rd_ptr_q] : BUBBLE;
        count_o     = count_q;
        push        = in_valid_i & in_ready_o;
        pop         = out_valid_o & out_ready_i;
    end

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) begin
                wr_ptr_d = ptr_next(wr_ptr_q);
            end
            if (pop) begin
                rd_ptr_d = ptr_next(rd_ptr_q);
            end
            if (push && !pop) begin
                count_d = count_q + CntW'(1);
            end else if (!push && pop) begin
                count_d = count_q - CntW'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage needs no reset: entries are only visible once count covers them.
    always_ff @(posedge clk) begin
        if (push && !flush_i && !rst) begin
            mem_q[wr_ptr_q] <= in_data_i;
        end
    end

endmodule

// File: tb/tb_pipe_buf.sv
// Directed bench for pipe_buf: table-driven vectors on a DEPTH=2 instance plus
// hand-written wrap (DEPTH=3) and single-entry (DEPTH=1) sequences.
module tb_pipe_buf;

    localparam logic [31:0] Bub = 32'h0000_0013;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic        f2, iv2, ir2, ov2, or2;
    logic [31:0] id2, od2;
    logic [1:0]  c2;
    logic        f3, iv3, ir3, ov3, or3;
    logic [31:0] id3, od3;
    logic [1:0]  c3;
    logic        f1, iv1, ir1, ov1, or1;
    logic [31:0] id1, od1;
    logic        c1;

    pipe_buf #(.DATA_W(32), .DEPTH(2), .BUBBLE(Bub)) u_d2 (
        .clk(clk), .rst(rst), .flush_i(f2), .in_valid_i(iv2), .in_ready_o(ir2),
        .in_data_i(id2), .out_valid_o(ov2), .out_ready_i(or2), .out_data_o(od2),
        .count_o(c2)
    );
    pipe_buf #(.DATA_W(32), .DEPTH(3), .BUBBLE(Bub)) u_d3 (
        .clk(clk), .rst(rst), .flush_i(f3), .in_valid_i(iv3), .in_ready_o(ir3),
        .in_data_i(id3), .out_valid_o(ov3), .out_ready_i(or3), .out_data_o(od3),
        .count_o(c3)
    );
    pipe_buf #(.DATA_W(32), .DEPTH(1), .BUBBLE(Bub)) u_d1 (
        .clk(clk), .rst(rst), .flush_i(f1), .in_valid_i(iv1), .in_ready_o(ir1),
        .in_data_i(id1), .out_valid_o(ov1), .out_ready_i(or1), .out_data_o(od1),
        .count_o(c1)
    );

    typedef struct {
        logic        rst;
        logic        flush;
        logic        valid;
        logic [31:0] data;
        logic        ordy;
        int          cnt;
        logic        irdy;
        logic        ovld;
        logic [31:0] odata;
    } vec_t;

    vec_t vq[$];
    int checks = 0;
    int failures = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic add(input logic r, input logic f, input logic v, input logic [31:0] d,
                       input logic o, input int c, input logic ir, input logic ov,
                       input logic [31:0] od);
        vec_t x;
        x = '{rst: r, flush: f, valid: v, data: d, ordy: o, cnt: c, irdy: ir, ovld: ov,
              odata: od};
        vq.push_back(x);
    endtask

    initial begin
        int n_push, n_pop, mcnt, cyc, acc;
        logic do_pop, do_push;

        rst = 1'b1;
        {f2, iv2, or2} = '0; id2 = '0;
        {f3, iv3, or3} = '0; id3 = '0;
        {f1, iv1, or1} = '0; id1 = '0;

        // reset with a held push
        add(1, 0, 1, 32'hAA, 0, 0, 1, 0, Bub);
        add(1, 0, 1, 32'hAA, 0, 0, 1, 0, Bub);
        add(0, 0, 0, 32'h0,  1, 0, 1, 0, Bub);
        // streaming 1..8
        for (int d = 1; d <= 8; d++) add(0, 0, 1, d, 1, 1, 1, 1, d);
        add(0, 0, 0, 32'h0,  1, 0, 1, 0, Bub);
        // stall: 0x12 held upstream until space frees
        add(0, 0, 1, 32'h10, 0, 1, 1, 1, 32'h10);
        add(0, 0, 1, 32'h11, 0, 2, 0, 1, 32'h10);
        add(0, 0, 1, 32'h12, 0, 2, 0, 1, 32'h10);
        add(0, 0, 1, 32'h12, 1, 1, 1, 1, 32'h11);
        add(0, 0, 1, 32'h12, 1, 1, 1, 1, 32'h12);
        add(0, 0, 0, 32'h0,  1, 0, 1, 0, Bub);
        // flush at count=2 with simultaneous push of 0x55
        add(0, 0, 1, 32'h20, 0, 1, 1, 1, 32'h20);
        add(0, 0, 1, 32'h21, 0, 2, 0, 1, 32'h20);
        add(0, 1, 1, 32'h55, 1, 0, 1, 0, Bub);
        add(0, 0, 0, 32'h0,  1, 0, 1, 0, Bub);
        // flush at count=1 with push
        add(0, 0, 1, 32'h30, 0, 1, 1, 1, 32'h30);
        add(0, 1, 1, 32'h31, 0, 0, 1, 0, Bub);
        add(0, 0, 0, 32'h0,  1, 0, 1, 0, Bub);
        // reset overrides flush and push
        add(0, 0, 1, 32'h40, 0, 1, 1, 1, 32'h40);
        add(1, 1, 1, 32'h41, 1, 0, 1, 0, Bub);
        add(0, 0, 0, 32'h0,  1, 0, 1, 0, Bub);

        for (int i = 0; i < vq.size(); i++) begin
            rst = vq[i].rst; f2 = vq[i].flush; iv2 = vq[i].valid;
            id2 = vq[i].data; or2 = vq[i].ordy;
            @(posedge clk); #1;
            check($sformatf("vec%0d_count", i), 32'(c2), 32'(vq[i].cnt));
            check($sformatf("vec%0d_in_ready", i), 32'(ir2), 32'(vq[i].irdy));
            check($sformatf("vec%0d_out_valid", i), 32'(ov2), 32'(vq[i].ovld));
            check($sformatf("vec%0d_out_data", i), od2, vq[i].odata);
        end
        {f2, iv2, or2} = '0;
        rst = 1'b0;

        // DEPTH=3 wrap with random back-pressure
        n_push = 0; n_pop = 0; mcnt = 0; cyc = 0;
        while (n_pop < 100 && cyc < 3000) begin
            check("wrap_count", 32'(c3), 32'(mcnt));
            check("wrap_in_ready", 32'(ir3), 32'(mcnt != 3));
            check("wrap_out_valid", 32'(ov3), 32'(mcnt != 0));
            or3 = 1'($urandom_range(0, 1));
            iv3 = (n_push < 100);
            id3 = n_push;
            do_pop  = (mcnt != 0) && or3;
            do_push = iv3 && (mcnt != 3);
            if (do_pop) begin
                check("wrap_data", od3, n_pop);
                n_pop++;
            end
            if (do_push) n_push++;
            mcnt = mcnt + int'(do_push) - int'(do_pop);
            @(posedge clk); #1;
            cyc++;
        end
        check("wrap_done", n_pop, 100);
        iv3 = 1'b0; or3 = 1'b0;

        // DEPTH=1: one word every two cycles
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        acc = 0;
        for (int k = 0; k < 10; k++) begin
            check($sformatf("d1_in_ready_%0d", k), 32'(ir1), 32'(k % 2 == 0));
            check($sformatf("d1_out_valid_%0d", k), 32'(ov1), 32'(k % 2 == 1));
            if (k % 2 == 1) check($sformatf("d1_out_data_%0d", k), od1, k / 2);
            iv1 = 1'b1; or1 = 1'b1; id1 = acc;
            if (ir1) acc++;
            @(posedge clk); #1;
        end
        iv1 = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
